// File: rtl/alu_result_checker_pkg.sv
// Shared definitions for the ALU result checker and its golden model.
package alu_result_checker_pkg;

  localparam int unsigned DATA_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StMonitor,
    StAlarm
  } chk_state_e;

endpackage

// File: rtl/alu_result_checker_if.sv
// Sample-in / verdict-out bundle between the ALU tap and the result checker.
interface alu_result_checker_if
  import alu_result_checker_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);

  logic              in_valid;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [1:0]        op_sel;
  logic [DATA_W-1:0] dut_res;
  logic              dut_cout;
  logic              clr;

  logic              chk_valid;
  logic              chk_mismatch;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic              alarm;
  logic [DATA_W-1:0] first_a;
  logic [DATA_W-1:0] first_b;
  logic [1:0]        first_op;

  // Sample source side: drives samples and clr, observes the verdicts.
  modport master (
    output in_valid, op_a, op_b, op_sel, dut_res, dut_cout, clr,
    input  chk_valid, chk_mismatch, mismatch_cnt, alarm, first_a, first_b, first_op
  );

  // Checker side.
  modport slave (
    input  in_valid, op_a, op_b, op_sel, dut_res, dut_cout, clr,
    output chk_valid, chk_mismatch, mismatch_cnt, alarm, first_a, first_b, first_op
  );

endinterface

// File: rtl/alu_golden_model.sv
// Combinational reference for the 4-bit ALU: ADD/SUB with carry/borrow, AND/OR.
module alu_golden_model
  import alu_result_checker_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              cout_o
);

  logic [DATA_W:0] wide;

  // One extra bit holds carry (ADD) or borrow (SUB: set exactly when a < b).
  always_comb begin
    wide = '0;
    case (op_i)
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      default: wide = '0;
    endcase
  end

  assign res_o  = wide[DATA_W-1:0];
  assign cout_o = wide[DATA_W];

endmodule

// File: rtl/alu_result_checker.sv
// Runtime golden-model checker for the ALU stage: counts result divergences,
// captures the first failing sample and raises a sticky alarm at a threshold.
module alu_result_checker
  import alu_result_checker_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ALARM_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax      = '1;
  localparam logic [CNT_W-1:0] AlarmThresh = CNT_W'(ALARM_THRESH);

  // Stage-1 sample registers
  logic              v1_q;
  logic [DATA_W-1:0] a1_q, b1_q, res1_q;
  logic [1:0]        op1_q;
  logic              cout1_q;

  // Stage-2 / architectural state
  chk_state_e        state_q, state_d;
  logic              chk_valid_q, chk_valid_d;
  logic              chk_mis_q, chk_mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alarm_q, alarm_d;
  logic [DATA_W-1:0] first_a_q, first_a_d, first_b_q, first_b_d;
  logic [1:0]        first_op_q, first_op_d;

  logic [DATA_W-1:0] g_res;
  logic              g_cout;
  logic              hit;

  // Stage 1: capture the sample; clr discards whatever is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      op1_q   <= '0;
      res1_q  <= '0;
      cout1_q <= 1'b0;
    end else if (bus.clr) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      op1_q   <= '0;
      res1_q  <= '0;
      cout1_q <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        a1_q    <= bus.op_a;
        b1_q    <= bus.op_b;
        op1_q   <= bus.op_sel;
        res1_q  <= bus.dut_res;
        cout1_q <= bus.dut_cout;
      end
    end
  end

  alu_golden_model u_golden (
    .a_i    (a1_q),
    .b_i    (b1_q),
    .op_i   (op1_q),
    .res_o  (g_res),
    .cout_o (g_cout)
  );

  assign hit = v1_q && ((g_res != res1_q) || (g_cout != cout1_q));

  // Stage 2: verdict, saturating count, first capture and FSM next state.
  always_comb begin
    state_d     = state_q;
    chk_valid_d = v1_q;
    chk_mis_d   = hit;
    cnt_d       = cnt_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    first_op_d  = first_op_q;

    if (hit && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // The count only returns to zero via clr/reset, so zero means "nothing captured yet".
    if (hit && (cnt_q == '0)) begin
      first_a_d  = a1_q;
      first_b_d  = b1_q;
      first_op_d = op1_q;
    end

    unique case (state_q)
      StIdle: begin
        // A threshold of 1 can be met by the very first check.
        if (v1_q) state_d = (cnt_d >= AlarmThresh) ? StAlarm : StMonitor;
      end
      StMonitor: begin
        if (cnt_d >= AlarmThresh) state_d = StAlarm;
      end
      StAlarm: begin
        state_d = StAlarm;
      end
      default: state_d = StIdle;
    endcase

    if (bus.clr) begin
      state_d     = StIdle;
      chk_valid_d = 1'b0;
      chk_mis_d   = 1'b0;
      cnt_d       = '0;
      first_a_d   = '0;
      first_b_d   = '0;
      first_op_d  = '0;
    end

    alarm_d = (state_d == StAlarm);
  end

  // Stage-2 output and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      chk_valid_q <= 1'b0;
      chk_mis_q   <= 1'b0;
      cnt_q       <= '0;
      alarm_q     <= 1'b0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      first_op_q  <= '0;
    end else begin
      state_q     <= state_d;
      chk_valid_q <= chk_valid_d;
      chk_mis_q   <= chk_mis_d;
      cnt_q       <= cnt_d;
      alarm_q     <= alarm_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      first_op_q  <= first_op_d;
    end
  end

  assign bus.chk_valid    = chk_valid_q;
  assign bus.chk_mismatch = chk_mis_q;
  assign bus.mismatch_cnt = cnt_q;
  assign bus.alarm        = alarm_q;
  assign bus.first_a      = first_a_q;
  assign bus.first_b      = first_b_q;
  assign bus.first_op     = first_op_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: default instance (CNT_W=8, threshold 3)
// plus a narrow instance (CNT_W=2, threshold 1) for saturation.
module tb_alu_result_checker;
  import alu_result_checker_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_result_checker_if #(.CNT_W(8)) bus0 ();
  alu_result_checker_if #(.CNT_W(2)) bus1 ();

  alu_result_checker #(.CNT_W(8), .ALARM_THRESH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  alu_result_checker #(.CNT_W(2), .ALARM_THRESH(1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] res, input logic cout);
    bus0.in_valid = 1'b1;
    bus0.op_sel   = op;
    bus0.op_a     = a;
    bus0.op_b     = b;
    bus0.dut_res  = res;
    bus0.dut_cout = cout;
  endtask

  task automatic drive1(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] res, input logic cout);
    bus1.in_valid = 1'b1;
    bus1.op_sel   = op;
    bus1.op_a     = a;
    bus1.op_b     = b;
    bus1.dut_res  = res;
    bus1.dut_cout = cout;
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.op_a = '0; bus0.op_b = '0; bus0.op_sel = '0;
    bus0.dut_res = '0; bus0.dut_cout = 1'b0; bus0.clr = 1'b0;
    bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.op_sel = '0;
    bus1.dut_res = '0; bus1.dut_cout = 1'b0; bus1.clr = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_chk_valid", bus0.chk_valid, 1'b0);
    check("rst_cnt", bus0.mismatch_cnt, 8'd0);
    check("rst_alarm", bus0.alarm, 1'b0);
    check("rst_first_a", bus0.first_a, 4'h0);
    check("rst_state", dut.state_q, StIdle);
    rst_n = 1'b1;
    tick();

    // ADD 7+9 = 1_0000, DUT agrees
    drive0(OP_ADD, 4'h7, 4'h9, 4'h0, 1'b1);
    tick();
    bus0.in_valid = 1'b0;
    check("add79_early", bus0.chk_valid, 1'b0);
    tick();
    check("add79_valid", bus0.chk_valid, 1'b1);
    check("add79_mis", bus0.chk_mismatch, 1'b0);
    check("add79_cnt", bus0.mismatch_cnt, 8'd0);
    check("add79_state", dut.state_q, StMonitor);
    tick();
    check("pulse_drop", bus0.chk_valid, 1'b0);

    // ADD F+F = 1_1110, DUT reports F/0
    drive0(OP_ADD, 4'hF, 4'hF, 4'hF, 1'b0);
    tick();
    bus0.in_valid = 1'b0;
    tick();
    check("addff_mis", bus0.chk_mismatch, 1'b1);
    check("addff_cnt", bus0.mismatch_cnt, 8'd1);
    check("addff_first_a", bus0.first_a, 4'hF);
    check("addff_first_b", bus0.first_b, 4'hF);
    check("addff_first_op", bus0.first_op, OP_ADD);

    // SUB 3-C = 1_0111 (borrow), DUT agrees
    drive0(OP_SUB, 4'h3, 4'hC, 4'h7, 1'b1);
    tick();
    bus0.in_valid = 1'b0;
    tick();
    check("sub3c_valid", bus0.chk_valid, 1'b1);
    check("sub3c_mis", bus0.chk_mismatch, 1'b0);
    check("sub3c_cnt", bus0.mismatch_cnt, 8'd1);

    // ADD 3+C = 0_1111, DUT reports carry 1
    drive0(OP_ADD, 4'h3, 4'hC, 4'hF, 1'b1);
    tick();
    bus0.in_valid = 1'b0;
    tick();
    check("add3c_mis", bus0.chk_mismatch, 1'b1);
    check("add3c_cnt", bus0.mismatch_cnt, 8'd2);
    check("add3c_first_a_kept", bus0.first_a, 4'hF);
    check("add3c_alarm", bus0.alarm, 1'b0);

    // Clear, then three back-to-back mismatches
    bus0.clr = 1'b1;
    tick();
    bus0.clr = 1'b0;
    check("clr_cnt", bus0.mismatch_cnt, 8'd0);
    check("clr_first_a", bus0.first_a, 4'h0);
    check("clr_state", dut.state_q, StIdle);

    drive0(OP_AND, 4'h5, 4'h6, 4'h5, 1'b0);   // golden 4/0
    tick();
    drive0(OP_OR, 4'h9, 4'h3, 4'hB, 1'b1);    // golden B/0
    tick();
    check("b2b1_valid", bus0.chk_valid, 1'b1);
    check("b2b1_cnt", bus0.mismatch_cnt, 8'd1);
    check("b2b1_alarm", bus0.alarm, 1'b0);
    drive0(OP_SUB, 4'h8, 4'h1, 4'h6, 1'b0);   // golden 7/0
    tick();
    bus0.in_valid = 1'b0;
    check("b2b2_valid", bus0.chk_valid, 1'b1);
    check("b2b2_cnt", bus0.mismatch_cnt, 8'd2);
    check("b2b2_alarm", bus0.alarm, 1'b0);
    tick();
    check("b2b3_valid", bus0.chk_valid, 1'b1);
    check("b2b3_cnt", bus0.mismatch_cnt, 8'd3);
    check("b2b3_alarm", bus0.alarm, 1'b1);
    check("b2b3_state", dut.state_q, StAlarm);
    tick();
    check("b2b_end", bus0.chk_valid, 1'b0);

    // Fourth mismatch: ADD 1+1 = 2, DUT reports 3
    drive0(OP_ADD, 4'h1, 4'h1, 4'h3, 1'b0);
    tick();
    bus0.in_valid = 1'b0;
    tick();
    check("m4_cnt", bus0.mismatch_cnt, 8'd4);
    check("m4_alarm", bus0.alarm, 1'b1);
    check("m4_first_a", bus0.first_a, 4'h5);
    check("m4_first_b", bus0.first_b, 4'h6);
    check("m4_first_op", bus0.first_op, OP_AND);

    // clr together with a mismatching sample, another one in flight
    drive0(OP_ADD, 4'h2, 4'h2, 4'h0, 1'b0);
    tick();
    drive0(OP_OR, 4'h1, 4'h2, 4'h0, 1'b0);
    bus0.clr = 1'b1;
    tick();
    bus0.clr = 1'b0;
    bus0.in_valid = 1'b0;
    check("clrmid_valid", bus0.chk_valid, 1'b0);
    check("clrmid_cnt", bus0.mismatch_cnt, 8'd0);
    check("clrmid_alarm", bus0.alarm, 1'b0);
    check("clrmid_first_op", bus0.first_op, 2'b00);
    check("clrmid_first_b", bus0.first_b, 4'h0);
    check("clrmid_state", dut.state_q, StIdle);
    tick();
    check("clrmid_flushed", bus0.chk_valid, 1'b0);
    check("clrmid_cnt2", bus0.mismatch_cnt, 8'd0);

    // Narrow instance: five mismatches saturate a 2-bit count
    drive1(OP_ADD, 4'h1, 4'h1, 4'h0, 1'b0);
    tick();
    tick();
    check("sat_first_cnt", bus1.mismatch_cnt, 2'd1);
    check("sat_first_alarm", bus1.alarm, 1'b1);
    repeat (3) tick();
    bus1.in_valid = 1'b0;
    tick();
    check("sat_cnt", bus1.mismatch_cnt, 2'd3);
    check("sat_alarm", bus1.alarm, 1'b1);
    tick();
    check("sat_hold", bus1.mismatch_cnt, 2'd3);

    // Asynchronous reset with a sample in flight
    drive0(OP_SUB, 4'h1, 4'h2, 4'h0, 1'b0);   // golden F/1
    tick();
    bus0.in_valid = 1'b0;
    tick();
    check("prerst_cnt", bus0.mismatch_cnt, 8'd1);
    drive0(OP_SUB, 4'h1, 4'h2, 4'h0, 1'b0);
    tick();
    bus0.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", bus0.mismatch_cnt, 8'd0);
    check("arst_first_a", bus0.first_a, 4'h0);
    check("arst_chk_valid", bus0.chk_valid, 1'b0);
    check("arst_sat_cnt", bus1.mismatch_cnt, 2'd0);
    check("arst_sat_alarm", bus1.alarm, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_valid", bus0.chk_valid, 1'b0);
    tick();
    check("postrst_cnt", bus0.mismatch_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
